// File: rtl/pe_operand_feeder_pkg.sv
// Shared definitions for the PE operand feeder: operand width and FSM state encoding.
package pe_operand_feeder_pkg;

  localparam int ACC_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/pe_operand_feeder_skew_line.sv
// DEPTH-register shift line carrying {valid, a, b} for one lane of the systolic skew.
module skew_line #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b
);

  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0][DATA_W-1:0] a_pipe;
  logic [DEPTH-1:0][DATA_W-1:0] b_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      a_pipe   <= '0;
      b_pipe   <= '0;
    end else begin
      vld_pipe[0] <= in_vld;
      a_pipe[0]   <= in_a;
      b_pipe[0]   <= in_b;
      for (int d = 1; d < DEPTH; d++) begin
        vld_pipe[d] <= vld_pipe[d-1];
        a_pipe[d]   <= a_pipe[d-1];
        b_pipe[d]   <= b_pipe[d-1];
      end
    end
  end

  assign out_vld = vld_pipe[DEPTH-1];
  assign out_a   = a_pipe[DEPTH-1];
  assign out_b   = b_pipe[DEPTH-1];

endmodule

// File: rtl/pe_operand_feeder.sv
// Feeds skewed A/B operand streams into a row of N MAC PEs; lane i lags by i extra cycles.
// Optional FEEDER_BUBBLE_CNT_EN adds a saturating count of starved FEED cycles (bubble_cnt).
module pe_operand_feeder
  import pe_operand_feeder_pkg::*;
#(
  parameter int DATA_W = ACC_DATA_W,
  parameter int N      = 4,
  parameter int KW     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KW-1:0]       k_len,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N*DATA_W-1:0] s_a,
  input  logic [N*DATA_W-1:0] s_b,
  output logic [N*DATA_W-1:0] pe_a,
  output logic [N*DATA_W-1:0] pe_b,
  output logic [N-1:0]        pe_valid,
  output logic                busy,
`ifdef FEEDER_BUBBLE_CNT_EN
  output logic [15:0]         bubble_cnt,
`endif
  output logic                done
);

  localparam int DCW = (N > 1) ? $clog2(N) : 1;

  state_e         state;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  beat_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           hs;

  assign s_ready = (state == S_FEED);
  assign hs      = s_valid & s_ready;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_q       <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          k_q       <= k_len;
          beat_cnt  <= '0;
          drain_cnt <= '0;
          state     <= (k_len == '0) ? S_DONE : S_FEED;
        end
        // Leave on the k_len-th beat; the counter tops out at k_len, so no wrap at 2^KW-1.
        S_FEED: if (hs) begin
          beat_cnt <= beat_cnt + KW'(1);
          if (beat_cnt + KW'(1) == k_q) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_cnt == DCW'(N-1)) state <= S_DONE;
          else drain_cnt <= drain_cnt + DCW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FEEDER_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  bubble_cnt <= '0;
    else if (state == S_IDLE && start)           bubble_cnt <= '0;
    else if (state == S_FEED && !s_valid && bubble_cnt != 16'hFFFF)
                                                 bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif

  // Non-handshake cycles inject zero operands so the PEs accumulate nothing.
  logic [N-1:0][DATA_W-1:0] a_in, b_in;
  assign a_in = hs ? s_a : '0;
  assign b_in = hs ? s_b : '0;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DATA_W(DATA_W), .DEPTH(i + 1)) u_skew (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (hs),
      .in_a    (a_in[i]),
      .in_b    (b_in[i]),
      .out_vld (pe_valid[i]),
      .out_a   (pe_a[i*DATA_W +: DATA_W]),
      .out_b   (pe_b[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Scoreboard bench for pe_operand_feeder (N=4, DATA_W=32, KW=8).
module tb_pe_operand_feeder;
  localparam int N = 4, DW = 32, KW = 8;

  logic            clk = 0, rst_n = 0, start = 0, s_valid = 0;
  logic [KW-1:0]   k_len = '0;
  logic [N*DW-1:0] s_a = '0, s_b = '0;
  logic [N*DW-1:0] pe_a, pe_b;
  logic [N-1:0]    pe_valid;
  logic            s_ready, busy, done;
`ifdef FEEDER_BUBBLE_CNT_EN
  logic [15:0]     bubble_cnt;
`endif

  pe_operand_feeder #(.DATA_W(DW), .N(N), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .pe_a(pe_a), .pe_b(pe_b), .pe_valid(pe_valid), .busy(busy),
`ifdef FEEDER_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } ent_t;

  ent_t sbq[N][$];
  int   cyc = 0, vectors = 0, miscompares = 0, hs_count = 0, last_hs = 0;
  bit   sb_en = 0;

  // Push one expected entry per lane on every handshake, due i+1 cycles later.
  always @(posedge clk) begin
    ent_t e;
    if (sb_en && rst_n && s_valid && s_ready) begin
      for (int l = 0; l < N; l++) begin
        e.due = cyc + 1 + l;
        e.a   = s_a[l*DW +: DW];
        e.b   = s_b[l*DW +: DW];
        sbq[l].push_back(e);
      end
      hs_count++;
      last_hs = cyc;
    end
    cyc++;
  end

  always @(negedge clk) begin
    ent_t e;
    logic [DW-1:0] ga, gb;
    if (sb_en) begin
      for (int l = 0; l < N; l++) begin
        ga = pe_a[l*DW +: DW];
        gb = pe_b[l*DW +: DW];
        vectors++;
        if (sbq[l].size() > 0 && sbq[l][0].due == cyc) begin
          e = sbq[l].pop_front();
          if (pe_valid[l] !== 1'b1 || ga !== e.a || gb !== e.b) begin
            miscompares++;
            $display("FAIL lane%0d beat @cyc%0d: got v=%b a=%h b=%h, want v=1 a=%h b=%h",
                     l, cyc, pe_valid[l], ga, gb, e.a, e.b);
          end
        end else if (pe_valid[l] !== 1'b0 || ga !== '0 || gb !== '0) begin
          miscompares++;
          $display("FAIL lane%0d bubble @cyc%0d: got v=%b a=%h b=%h, want v=0 a=0 b=0",
                   l, cyc, pe_valid[l], ga, gb);
        end
      end
    end
  end

  task automatic clear_sb();
    for (int l = 0; l < N; l++) sbq[l].delete();
  endtask

  task automatic start_run(input int kl);
    @(negedge clk);
    start = 1; k_len = KW'(kl);
    @(negedge clk);
    start = 0;
  endtask

  // Drive kl beats with a cyclic valid pattern; optional start poke at FEED cycle 'poke'.
  task automatic feed(input int kl, input logic [31:0] vpat, input int plen, input int poke);
    int beats = 0, idx = 0, guard = 0;
    logic v;
    while (beats < kl && guard < 4000) begin
      v = 0;
      if (s_ready) begin
        v = vpat[idx % plen];
        if (idx == poke) begin start = 1; k_len = 8'd9; end
        idx++;
      end
      s_valid = v;
      for (int l = 0; l < N; l++) begin
        s_a[l*DW +: DW] = v ? DW'(beats*N + l + 1) : $urandom;
        s_b[l*DW +: DW] = v ? DW'(beats*N + l + 101) : $urandom;
      end
      @(posedge clk);
      if (v) beats++;
      @(negedge clk);
      start = 0;
      guard++;
    end
    s_valid = 0;
    vectors++;
    if (beats != kl || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL feed_end: beats=%0d s_ready=%b, want beats=%0d s_ready=0", beats, s_ready, kl);
    end
  endtask

  task automatic wait_done();
    int g = 0;
    while (done !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    vectors++;
    if (done !== 1'b1 || cyc != last_hs + N + 1) begin
      miscompares++;
      $display("FAIL done_time: done=%b cyc=%0d, want done=1 cyc=%0d", done, cyc, last_hs + N + 1);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_done: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic check_idle(input string tag);
    vectors++;
    if (s_ready !== 0 || pe_a !== '0 || pe_b !== '0 || pe_valid !== '0 || busy !== 0 || done !== 0) begin
      miscompares++;
      $display("FAIL %s: s_ready=%b pe_valid=%b busy=%b done=%b pe_a=%h pe_b=%h, want all 0",
               tag, s_ready, pe_valid, busy, done, pe_a, pe_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; s_valid = 1; sb_en = 0; clear_sb();
    repeat (3) @(negedge clk);
    check_idle("reset_hold");
    rst_n = 1; s_valid = 0;
    repeat (2) @(negedge clk);
    check_idle("reset_release");
    sb_en = 1;
  endtask

  task automatic test_continuous();
    int h0 = hs_count;
    start_run(3);
    feed(3, 32'h1, 1, -1);
    wait_done();
    vectors++;
    if (hs_count - h0 != 3) begin
      miscompares++;
      $display("FAIL cont_beats: got %0d, want 3", hs_count - h0);
    end
  endtask

  task automatic test_bubbles();
    start_run(2);
    feed(2, 32'b1001, 4, -1);
    wait_done();
`ifdef FEEDER_BUBBLE_CNT_EN
    vectors++;
    if (bubble_cnt !== 16'd2) begin
      miscompares++;
      $display("FAIL bubble_cnt: got %0d, want 2", bubble_cnt);
    end
`endif
  endtask

  task automatic test_zero_len();
    int c0;
    bit saw_ready = 0;
    @(negedge clk);
    start = 1; k_len = '0; c0 = cyc;
    @(negedge clk);
    start = 0;
    if (s_ready) saw_ready = 1;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || cyc != c0 + 1) begin
      miscompares++;
      $display("FAIL zero_done: done=%b busy=%b cyc=%0d, want 1 1 %0d", done, busy, cyc, c0 + 1);
    end
    repeat (2) begin
      @(negedge clk);
      if (s_ready) saw_ready = 1;
    end
    vectors++;
    if (saw_ready || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_after: s_ready_seen=%b done=%b busy=%b, want 0 0 0", saw_ready, done, busy);
    end
  endtask

  task automatic test_interference();
    int h0 = hs_count;
    start_run(3);
    feed(3, 32'h1, 1, 1);
    wait_done();
    vectors++;
    if (hs_count - h0 != 3) begin
      miscompares++;
      $display("FAIL restart_ignored: beats=%0d, want 3", hs_count - h0);
    end
    start_run(5);
    s_valid = 1;
    for (int k = 0; k < 2; k++) begin
      for (int l = 0; l < N; l++) begin
        s_a[l*DW +: DW] = DW'(32'hA000 + k*N + l);
        s_b[l*DW +: DW] = DW'(32'hB000 + k*N + l);
      end
      @(negedge clk);
    end
    #2 rst_n = 0; sb_en = 0; clear_sb();
    #1 check_idle("async_reset");
    @(negedge clk);
    rst_n = 1; s_valid = 0;
    @(negedge clk);
    check_idle("post_reset");
    sb_en = 1;
  endtask

  task automatic test_back_to_back();
    int h0 = hs_count;
    start_run(255);
    feed(255, 32'h1, 1, -1);
    wait_done();
    vectors++;
    if (hs_count - h0 != 255) begin
      miscompares++;
      $display("FAIL max_len_beats: got %0d, want 255", hs_count - h0);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_bubbles();
    test_zero_len();
    test_interference();
    test_back_to_back();
    repeat (N + 2) @(negedge clk);
    for (int l = 0; l < N; l++) begin
      vectors++;
      if (sbq[l].size() != 0) begin
        miscompares++;
        $display("FAIL sb_drain lane%0d: %0d entries left, want 0", l, sbq[l].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
